// File: rtl/fft_mux_16x1_collect.sv
// fft_mux_16x1_collect
// Collects NUM_LANES parallel FFT lanes back into one in-order serial stream.
// Each lane owns a single-entry holding register. A lane pointer drains the
// holds strictly in order 0..NUM_LANES-1 and wraps. A lane that arrives ahead
// of the pointer stays parked with its ready low until the pointer reaches it.
// Lane ready depends on the hold state only, never on the input valid.
module fft_mux_16x1_collect #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 16,
  localparam int SEL_WIDTH = $clog2(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_LANES-1:0]            data_i_valid,
  output logic [NUM_LANES-1:0]            data_i_ready,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [SEL_WIDTH-1:0]            data_o_sel,
  output logic                            data_o_valid,
  output logic                            data_o_last,
  input  logic                            data_o_ready,
  output logic [SEL_WIDTH:0]              hold_count
);

  logic [DATA_WIDTH-1:0] hold_data [NUM_LANES];
  logic [NUM_LANES-1:0]  hold_full;
  logic [NUM_LANES-1:0]  capture;
  logic [NUM_LANES-1:0]  drain_mask;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH:0]    cap_count;
  logic                  out_free;
  logic                  drain;

  // A full lane is never ready, so capture and drain of one lane cannot
  // happen on the same edge; a lane freed by a drain reads ready next cycle.
  assign data_i_ready = ~hold_full;
  assign capture      = data_i_valid & ~hold_full;
  assign out_free     = ~data_o_valid | data_o_ready;
  assign drain        = hold_full[ptr] & out_free;

  // One-hot mask of the lane being drained on this edge.
  always_comb begin
    drain_mask = '0;
    if (drain) begin
      drain_mask[ptr] = 1'b1;
    end
  end

  // Number of lanes captured on this edge, used to keep hold_count registered.
  always_comb begin
    cap_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cap_count = cap_count + (SEL_WIDTH+1)'(capture[i]);
    end
  end

  // Lane data registers; contents are only meaningful while hold_full is set,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (capture[i]) begin
        hold_data[i] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Hold occupancy, drain pointer and output register; clear wins over
  // both capture and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full    <= '0;
      ptr          <= '0;
      hold_count   <= '0;
      data_o       <= '0;
      data_o_sel   <= '0;
      data_o_valid <= 1'b0;
      data_o_last  <= 1'b0;
    end else if (clear) begin
      hold_full    <= '0;
      ptr          <= '0;
      hold_count   <= '0;
      data_o_valid <= 1'b0;
      data_o_last  <= 1'b0;
    end else begin
      hold_full  <= (hold_full | capture) & ~drain_mask;
      hold_count <= hold_count + cap_count - (SEL_WIDTH+1)'(drain);
      if (drain) begin
        data_o       <= hold_data[ptr];
        data_o_sel   <= ptr;
        data_o_valid <= 1'b1;
        data_o_last  <= (ptr == SEL_WIDTH'(NUM_LANES - 1));
        ptr          <= ptr + SEL_WIDTH'(1);
      end else if (data_o_ready) begin
        data_o_valid <= 1'b0;
        data_o_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_mux_16x1_collect.sv
// Testbench for fft_mux_16x1_collect: reset state, in-order frame, an
// out-of-order table, back-pressure with frame wrap, clear and async reset.
module tb_fft_mux_16x1_collect;

  localparam int DW = 8;
  localparam int NL = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic [NL*DW-1:0]  data_i;
  logic [NL-1:0]     data_i_valid;
  logic [NL-1:0]     data_i_ready;
  logic [DW-1:0]     data_o;
  logic [3:0]        data_o_sel;
  logic              data_o_valid;
  logic              data_o_last;
  logic              data_o_ready;
  logic [4:0]        hold_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] valid;
    logic        rdy;
    logic        ev;
    logic [3:0]  esel;
    logic [7:0]  edata;
    logic        elast;
    logic [4:0]  ecnt;
    logic [15:0] eir;
  } vec_t;

  vec_t tbl [9];

  fft_mux_16x1_collect #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .data_i       (data_i),
    .data_i_valid (data_i_valid),
    .data_i_ready (data_i_ready),
    .data_o       (data_o),
    .data_o_sel   (data_o_sel),
    .data_o_valid (data_o_valid),
    .data_o_last  (data_o_last),
    .data_o_ready (data_o_ready),
    .hold_count   (hold_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] s,
                         input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(data_o_valid), 32'(v));
    chk({tag, ".sel"},   32'(data_o_sel),   32'(s));
    chk({tag, ".data"},  32'(data_o),       32'(d));
    chk({tag, ".last"},  32'(data_o_last),  32'(l));
  endtask

  task automatic drive(input logic [15:0] v, input logic [7:0] base);
    data_i_valid = v;
    for (int i = 0; i < NL; i++) begin
      data_i[i*DW +: DW] = base + 8'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // out-of-order lanes 3,1,0,2 while a held sel=15 sample blocks the output
    tbl[0] = '{16'h0008, 1'b0, 1'b1, 4'd15, 8'h1F, 1'b1, 5'd1, 16'hFFF7};
    tbl[1] = '{16'h0002, 1'b0, 1'b1, 4'd15, 8'h1F, 1'b1, 5'd2, 16'hFFF5};
    tbl[2] = '{16'h0001, 1'b0, 1'b1, 4'd15, 8'h1F, 1'b1, 5'd3, 16'hFFF4};
    tbl[3] = '{16'h0004, 1'b0, 1'b1, 4'd15, 8'h1F, 1'b1, 5'd4, 16'hFFF0};
    tbl[4] = '{16'h0000, 1'b1, 1'b1, 4'd0,  8'h40, 1'b0, 5'd3, 16'hFFF1};
    tbl[5] = '{16'h0000, 1'b1, 1'b1, 4'd1,  8'h41, 1'b0, 5'd2, 16'hFFF3};
    tbl[6] = '{16'h0000, 1'b1, 1'b1, 4'd2,  8'h42, 1'b0, 5'd1, 16'hFFF7};
    tbl[7] = '{16'h0000, 1'b1, 1'b1, 4'd3,  8'h43, 1'b0, 5'd0, 16'hFFFF};
    tbl[8] = '{16'h0000, 1'b1, 1'b0, 4'd3,  8'h43, 1'b0, 5'd0, 16'hFFFF};

    rst = 1'b1;
    clear = 1'b0;
    data_o_ready = 1'b1;
    drive(16'h0000, 8'h00);

    // reset state
    #12;
    chk_out("rst", 1'b0, 4'd0, 8'h00, 1'b0);
    chk("rst.cnt", 32'(hold_count), 32'd0);
    chk("rst.ready", 32'(data_i_ready), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle.valid", 32'(data_o_valid), 32'd0);
      chk("idle.cnt", 32'(hold_count), 32'd0);
    end

    // in-order full frame, first output two cycles after acceptance
    drive(16'hFFFF, 8'h10);
    tick();
    chk("inord.accept.valid", 32'(data_o_valid), 32'd0);
    chk("inord.accept.cnt", 32'(hold_count), 32'd16);
    chk("inord.accept.ready", 32'(data_i_ready), 32'h0000);
    drive(16'h0000, 8'h10);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_out($sformatf("inord[%0d]", i), 1'b1, 4'(i), 8'h10 + 8'(i), i == 15);
      chk($sformatf("inord[%0d].cnt", i), 32'(hold_count), 32'(15 - i));
      if (i == 15) data_o_ready = 1'b0;
    end

    // out-of-order arrival, table driven
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].valid, 8'h40);
      data_o_ready = tbl[r].rdy;
      tick();
      chk_out($sformatf("ooo[%0d]", r), tbl[r].ev, tbl[r].esel, tbl[r].edata, tbl[r].elast);
      chk($sformatf("ooo[%0d].cnt", r), 32'(hold_count), 32'(tbl[r].ecnt));
      chk($sformatf("ooo[%0d].ready", r), 32'(data_i_ready), 32'(tbl[r].eir));
    end

    // back-pressure mid-frame, then wrap into a second frame
    reset_pulse();
    data_o_ready = 1'b1;
    drive(16'h0000, 8'h00);
    tick();
    drive(16'hFFFF, 8'h50);
    tick();
    chk("bp.accept.cnt", 32'(hold_count), 32'd16);
    drive(16'hFFFF, 8'h60);
    for (int n = 0; n < 32; n++) begin
      tick();
      chk_out($sformatf("stream[%0d]", n), 1'b1, 4'(n % 16),
              ((n < 16) ? 8'h50 : 8'h60) + 8'(n % 16), (n % 16) == 15);
      if (n == 5) begin
        data_o_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk_out($sformatf("stall[%0d]", s), 1'b1, 4'd5, 8'h55, 1'b0);
        end
        chk("stall.cnt", 32'(hold_count), 32'd16);
        data_o_ready = 1'b1;
      end
    end

    // clear after five lanes drained; same-cycle captures discarded
    reset_pulse();
    drive(16'h0000, 8'h00);
    tick();
    drive(16'hFFFF, 8'h70);
    tick();
    drive(16'h0000, 8'h70);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_out($sformatf("pre_clr[%0d]", n), 1'b1, 4'(n), 8'h70 + 8'(n), 1'b0);
    end
    clear = 1'b1;
    drive(16'hFFFF, 8'h77);
    tick();
    clear = 1'b0;
    drive(16'h0000, 8'h77);
    chk("clr.valid", 32'(data_o_valid), 32'd0);
    chk("clr.last", 32'(data_o_last), 32'd0);
    chk("clr.cnt", 32'(hold_count), 32'd0);
    chk("clr.ready", 32'(data_i_ready), 32'hFFFF);
    drive(16'hFFFF, 8'h80);
    tick();
    drive(16'h0000, 8'h80);
    tick();
    chk_out("post_clr", 1'b1, 4'd0, 8'h80, 1'b0);
    chk("post_clr.cnt", 32'(hold_count), 32'd15);
    for (int n = 1; n < 5; n++) begin
      tick();
      chk_out($sformatf("pre_rst[%0d]", n), 1'b1, 4'(n), 8'h80 + 8'(n), 1'b0);
    end

    // async reset between edges mid-frame
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(data_o_valid), 32'd0);
    chk("arst.cnt", 32'(hold_count), 32'd0);
    chk("arst.ready", 32'(data_i_ready), 32'hFFFF);
    #1;
    rst = 1'b0;
    drive(16'hFFFF, 8'h90);
    tick();
    drive(16'h0000, 8'h90);
    tick();
    chk_out("post_rst", 1'b1, 4'd0, 8'h90, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
